// File: rtl/mdio_slave_mdc_sampler.sv
`default_nettype none
// ============================================================================
// Module      : mdio_slave_mdc_sampler
// Description : MDIO slave frontend in the clk_25m domain. Oversamples MDC and
//               MDIO, detects preamble and start of frame, assembles the
//               32-bit frame, raises field-done strobes, and drives read data
//               back during turnaround and data phases.
//               Optional build macro: MDIO_PREAMBLE_SUPPRESS_EN (accept a
//               start bit after a short or absent preamble).
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_slave_mdc_sampler #(
    parameter int TIMEOUT_CYC = 256,
    parameter int PRE_LEN     = 32
) (
    input  logic        clk_25m,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_in,
    input  logic [4:0]  phy_addr,
    input  logic [15:0] resp_rdata,
    input  logic        resp_ready,
    output logic [31:0] rx_data,
    output logic        phyaddr_done_pos,
    output logic        info_done_pos,
    output logic        data_done_pos,
    output logic        legal,
    output logic        time_out_flag,
    output logic        mdio_out,
    output logic        mdio_oe
);

    localparam int c_PRE_W = $clog2(PRE_LEN + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRE_LEN);
    localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TX    = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_mdc_sync;
    logic [1:0]         r_mdio_sync;
    logic [31:0]        r_rx_data;
    logic [5:0]         r_bit_cnt;
    logic [c_PRE_W-1:0] r_pre_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic               r_phyaddr_done;
    logic               r_info_done;
    logic               r_data_done;
    logic               r_time_out;
    logic               r_legal;
    logic               r_is_read;
    logic               r_mdio_oe;
    logic               r_mdio_out;
    logic [15:0]        r_hold;
    logic               r_hold_vld;
    logic [15:0]        r_tx_sh;

    logic               w_rise;
    logic               w_fall;
    logic               w_bit;
    logic               w_start_ok;
    logic [15:0]        w_src;

    // Two-flop synchronizers; the third MDC flop provides edge detection
    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            r_mdc_sync  <= 3'b000;
            r_mdio_sync <= 2'b00;
        end else begin
            r_mdc_sync  <= {r_mdc_sync[1:0], mdc};
            r_mdio_sync <= {r_mdio_sync[0], mdio_in};
        end
    end

    assign w_rise = r_mdc_sync[1] & ~r_mdc_sync[2];
    assign w_fall = ~r_mdc_sync[1] & r_mdc_sync[2];
    assign w_bit  = r_mdio_sync[1];

    // A response arriving in the same cycle as the load edge takes priority
    assign w_src = resp_ready ? resp_rdata : (r_hold_vld ? r_hold : 16'hFFFF);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic r_b2b;
    // Remembers that IDLE was entered from a completed frame with no bit sampled since
    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            r_b2b <= 1'b0;
        end else if (r_data_done) begin
            r_b2b <= 1'b1;
        end else if (w_rise || r_time_out) begin
            r_b2b <= 1'b0;
        end
    end
    assign w_start_ok = (r_pre_cnt != '0) || r_b2b;
`else
    assign w_start_ok = (r_pre_cnt == c_PRE_MAX);
`endif

    // Frame FSM: preamble hunt, bit assembly, read response and inactivity timeout
    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_rx_data      <= '0;
            r_bit_cnt      <= '0;
            r_pre_cnt      <= '0;
            r_to_cnt       <= '0;
            r_phyaddr_done <= 1'b0;
            r_info_done    <= 1'b0;
            r_data_done    <= 1'b0;
            r_time_out     <= 1'b0;
            r_legal        <= 1'b0;
            r_is_read      <= 1'b0;
            r_mdio_oe      <= 1'b0;
            r_mdio_out     <= 1'b1;
            r_hold         <= '0;
            r_hold_vld     <= 1'b0;
            r_tx_sh        <= '0;
        end else begin
            r_phyaddr_done <= 1'b0;
            r_info_done    <= 1'b0;
            r_data_done    <= 1'b0;
            r_time_out     <= 1'b0;

            if (resp_ready && (r_state != ST_IDLE)) begin
                r_hold     <= resp_rdata;
                r_hold_vld <= 1'b1;
            end

            if ((r_state == ST_IDLE) || w_rise) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    r_legal    <= 1'b0;
                    r_hold_vld <= 1'b0;
                    r_is_read  <= 1'b0;
                    if (w_rise) begin
                        if (w_bit) begin
                            if (r_pre_cnt != c_PRE_MAX) begin
                                r_pre_cnt <= r_pre_cnt + c_PRE_W'(1);
                            end
                        end else if (w_start_ok) begin
                            // Start bit ST[0]=0 is frame bit 0
                            r_rx_data <= '0;
                            r_bit_cnt <= 6'd1;
                            r_pre_cnt <= '0;
                            r_state   <= ST_SHIFT;
                        end else begin
                            r_pre_cnt <= '0;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (w_rise) begin
                        r_rx_data[5'd31 - r_bit_cnt[4:0]] <= w_bit;
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                        if (r_bit_cnt == 6'd8) begin
                            r_phyaddr_done <= 1'b1;
                            r_legal        <= ({r_rx_data[27:24], w_bit} == phy_addr);
                        end
                        if (r_bit_cnt == 6'd13) begin
                            r_info_done <= 1'b1;
                            // Cl22 read (0110) or Cl45 read / read-increment (0011, 0010)
                            r_is_read   <= r_legal &&
                                           ((r_rx_data[31:28] == 4'b0110) ||
                                            (r_rx_data[31:29] == 3'b001));
                        end
                        if (r_bit_cnt == 6'd31) begin
                            r_data_done <= 1'b1;
                            r_pre_cnt   <= '0;
                            r_state     <= ST_IDLE;
                        end
                    end else if (w_fall && r_is_read && (r_bit_cnt == 6'd15)) begin
                        // Drive the second turnaround bit low
                        r_mdio_oe  <= 1'b1;
                        r_mdio_out <= 1'b0;
                        r_state    <= ST_TX;
                    end
                end

                ST_TX: begin
                    if (w_rise) begin
                        if (r_bit_cnt != 6'd32) begin
                            r_rx_data[5'd31 - r_bit_cnt[4:0]] <= w_bit;
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                            if (r_bit_cnt == 6'd31) begin
                                r_data_done <= 1'b1;
                            end
                        end
                    end else if (w_fall) begin
                        if (r_bit_cnt == 6'd32) begin
                            r_mdio_oe  <= 1'b0;
                            r_mdio_out <= 1'b1;
                            r_pre_cnt  <= '0;
                            r_state    <= ST_IDLE;
                        end else if (r_bit_cnt == 6'd16) begin
                            r_mdio_out <= w_src[15];
                            r_tx_sh    <= {w_src[14:0], 1'b0};
                        end else if (r_bit_cnt > 6'd16) begin
                            r_mdio_out <= r_tx_sh[15];
                            r_tx_sh    <= {r_tx_sh[14:0], 1'b0};
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // MDC inactivity abort; a coincident rise resets the counter instead
            if ((r_state != ST_IDLE) && !w_rise && (r_to_cnt == c_TO_LAST)) begin
                r_time_out <= 1'b1;
                r_legal    <= 1'b0;
                r_mdio_oe  <= 1'b0;
                r_mdio_out <= 1'b1;
                r_pre_cnt  <= '0;
                r_to_cnt   <= '0;
                r_state    <= ST_IDLE;
            end
        end
    end

    assign rx_data          = r_rx_data;
    assign phyaddr_done_pos = r_phyaddr_done;
    assign info_done_pos    = r_info_done;
    assign data_done_pos    = r_data_done;
    assign legal            = r_legal;
    assign time_out_flag    = r_time_out;
    assign mdio_out         = r_mdio_out;
    assign mdio_oe          = r_mdio_oe;

endmodule
`default_nettype wire

// File: tb/tb_mdio_slave_mdc_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdio_slave_mdc_sampler
// Description : Directed self-checking bench for mdio_slave_mdc_sampler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_slave_mdc_sampler;

    localparam int TIMEOUT_CYC = 256;
    localparam int PRE_LEN     = 32;

    logic        clk_25m = 1'b0;
    logic        rst_n   = 1'b0;
    logic        mdc     = 1'b0;
    logic        tb_drv  = 1'b1;
    logic [4:0]  phy_addr = 5'd5;
    logic [15:0] resp_rdata = 16'h0000;
    logic        resp_ready = 1'b0;
    logic [31:0] rx_data;
    logic        phyaddr_done_pos, info_done_pos, data_done_pos;
    logic        legal, time_out_flag, mdio_out, mdio_oe;
    wire         mdio_line;

    // Shared line: slave drive wins, otherwise master drive (released = 1)
    assign mdio_line = mdio_oe ? mdio_out : tb_drv;

    mdio_slave_mdc_sampler #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .PRE_LEN    (PRE_LEN)
    ) dut (
        .clk_25m         (clk_25m),
        .rst_n           (rst_n),
        .mdc             (mdc),
        .mdio_in         (mdio_line),
        .phy_addr        (phy_addr),
        .resp_rdata      (resp_rdata),
        .resp_ready      (resp_ready),
        .rx_data         (rx_data),
        .phyaddr_done_pos(phyaddr_done_pos),
        .info_done_pos   (info_done_pos),
        .data_done_pos   (data_done_pos),
        .legal           (legal),
        .time_out_flag   (time_out_flag),
        .mdio_out        (mdio_out),
        .mdio_oe         (mdio_oe)
    );

    always #20 clk_25m = ~clk_25m;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe monitor
    int          cnt_pa, cnt_info, cnt_dd, cnt_to;
    logic [31:0] cap_pa_rx, cap_dd_rx;
    logic        cap_pa_legal, cap_dd_oe, oe_seen;

    always @(negedge clk_25m) begin
        if (phyaddr_done_pos) begin
            cnt_pa++;
            cap_pa_rx    = rx_data;
            cap_pa_legal = legal;
        end
        if (info_done_pos) cnt_info++;
        if (data_done_pos) begin
            cnt_dd++;
            cap_dd_rx = rx_data;
            cap_dd_oe = mdio_oe;
        end
        if (time_out_flag) cnt_to++;
        if (mdio_oe) oe_seen = 1'b1;
    end

    task automatic clear_mon();
        cnt_pa = 0; cnt_info = 0; cnt_dd = 0; cnt_to = 0;
        cap_pa_rx = '0; cap_dd_rx = '0; cap_pa_legal = 1'b0;
        cap_dd_oe = 1'b0; oe_seen = 1'b0;
    endtask

    // One MDC period: master sets data in low phase, slave samples at rising edge
    task automatic mdc_bit(input logic b);
        tb_drv = b;
        repeat (8) @(negedge clk_25m);
        mdc = 1'b1;
        repeat (8) @(negedge clk_25m);
        mdc = 1'b0;
    endtask

    task automatic send_pre(input int n);
        for (int i = 0; i < n; i++) mdc_bit(1'b1);
    endtask

    // Frame bits from..to; from rel_from on the master releases the line
    task automatic send_bits(input logic [31:0] f, input int from, input int to, input int rel_from);
        for (int i = from; i <= to; i++) begin
            if (rel_from >= 0 && i >= rel_from) mdc_bit(1'b1);
            else mdc_bit(f[31-i]);
        end
    endtask

    task automatic idle_gap();
        tb_drv = 1'b1;
        repeat (20) @(negedge clk_25m);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk_25m);
        n_checks++;
        if (rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_rx: got %h, expected %h", rx_data, 32'h0); end
        n_checks++;
        if ({phyaddr_done_pos, info_done_pos, data_done_pos, time_out_flag, legal, mdio_oe, mdio_out} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_outs: got %b, expected %b",
                     {phyaddr_done_pos, info_done_pos, data_done_pos, time_out_flag, legal, mdio_oe, mdio_out}, 7'b0000001);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk_25m);
    endtask

    task automatic test_cl22_write();
        logic [31:0] f;
        f = {2'b01, 2'b01, 5'd5, 5'd3, 2'b10, 16'hA55A};
        clear_mon();
        send_pre(32);
        send_bits(f, 0, 31, -1);
        idle_gap();
        n_checks++;
        if (cnt_pa !== 1 || cap_pa_rx[31:30] !== 2'b01) begin
            n_fail++; $display("FAIL wr_phyaddr: got cnt %0d st %b, expected cnt 1 st 01", cnt_pa, cap_pa_rx[31:30]);
        end
        n_checks++;
        if (cap_pa_legal !== 1'b1) begin n_fail++; $display("FAIL wr_legal: got %b, expected 1", cap_pa_legal); end
        n_checks++;
        if (cnt_info !== 1) begin n_fail++; $display("FAIL wr_info: got %0d, expected 1", cnt_info); end
        n_checks++;
        if (cnt_dd !== 1 || cap_dd_rx[15:0] !== 16'hA55A) begin
            n_fail++; $display("FAIL wr_data: got cnt %0d data %h, expected cnt 1 data a55a", cnt_dd, cap_dd_rx[15:0]);
        end
        n_checks++;
        if (cap_dd_rx !== f) begin n_fail++; $display("FAIL wr_frame: got %h, expected %h", cap_dd_rx, f); end
        n_checks++;
        if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL wr_no_drive: got %b, expected 0", oe_seen); end
    endtask

    task automatic test_cl22_read();
        logic [31:0] f;
        logic [31:0] exp_rx;
        f      = {2'b01, 2'b10, 5'd5, 5'd2, 2'b11, 16'h0000};
        exp_rx = {2'b01, 2'b10, 5'd5, 5'd2, 2'b10, 16'h1234};
        clear_mon();
        send_pre(32);
        send_bits(f, 0, 13, -1);
        @(negedge clk_25m);
        resp_rdata = 16'h1234;
        resp_ready = 1'b1;
        @(negedge clk_25m);
        resp_ready = 1'b0;
        resp_rdata = 16'hDEAD;
        send_bits(f, 14, 31, 14);
        n_checks++;
        if (mdio_oe !== 1'b1) begin n_fail++; $display("FAIL rd_oe_held: got %b, expected 1", mdio_oe); end
        repeat (6) @(negedge clk_25m);
        n_checks++;
        if (mdio_oe !== 1'b0 || mdio_out !== 1'b1) begin
            n_fail++; $display("FAIL rd_release: got oe %b out %b, expected oe 0 out 1", mdio_oe, mdio_out);
        end
        idle_gap();
        n_checks++;
        if (cap_dd_rx !== exp_rx) begin n_fail++; $display("FAIL rd_frame: got %h, expected %h", cap_dd_rx, exp_rx); end
        n_checks++;
        if (cap_dd_oe !== 1'b1) begin n_fail++; $display("FAIL rd_oe_at_done: got %b, expected 1", cap_dd_oe); end
    endtask

    task automatic test_cl45_read_default();
        logic [31:0] f;
        logic [31:0] exp_rx;
        f      = {2'b00, 2'b11, 5'd5, 5'd1, 2'b11, 16'h0000};
        exp_rx = {2'b00, 2'b11, 5'd5, 5'd1, 2'b10, 16'hFFFF};
        clear_mon();
        tb_drv = 1'b1;
        send_pre(32);
        send_bits(f, 0, 31, 14);
        idle_gap();
        n_checks++;
        if (cap_dd_rx !== exp_rx) begin n_fail++; $display("FAIL c45_frame: got %h, expected %h", cap_dd_rx, exp_rx); end
        n_checks++;
        if (oe_seen !== 1'b1 || mdio_oe !== 1'b0) begin
            n_fail++; $display("FAIL c45_drive: got seen %b now %b, expected seen 1 now 0", oe_seen, mdio_oe);
        end
    endtask

    task automatic test_phy_mismatch();
        logic [31:0] f;
        logic [31:0] exp_rx;
        f      = {2'b01, 2'b10, 5'd6, 5'd2, 2'b11, 16'h0000};
        exp_rx = {2'b01, 2'b10, 5'd6, 5'd2, 2'b11, 16'hFFFF};
        clear_mon();
        send_pre(32);
        send_bits(f, 0, 31, 14);
        idle_gap();
        n_checks++;
        if (cap_pa_legal !== 1'b0) begin n_fail++; $display("FAIL nm_legal: got %b, expected 0", cap_pa_legal); end
        n_checks++;
        if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL nm_no_drive: got %b, expected 0", oe_seen); end
        n_checks++;
        if (cnt_pa !== 1 || cnt_info !== 1 || cnt_dd !== 1) begin
            n_fail++; $display("FAIL nm_strobes: got %0d/%0d/%0d, expected 1/1/1", cnt_pa, cnt_info, cnt_dd);
        end
        n_checks++;
        if (cap_dd_rx !== exp_rx) begin n_fail++; $display("FAIL nm_frame: got %h, expected %h", cap_dd_rx, exp_rx); end
    endtask

    task automatic test_timeout();
        logic [31:0] f;
        int          j;
        f = {2'b01, 2'b01, 5'd5, 5'd7, 2'b10, 16'h3C96};
        clear_mon();
        send_pre(32);
        send_bits(f, 0, 20, -1);
        n_checks++;
        if (legal !== 1'b1) begin n_fail++; $display("FAIL to_legal_before: got %b, expected 1", legal); end
        j = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk_25m);
            if (time_out_flag) begin j = k; break; end
        end
        // Last pin rise was 8 cycles before the loop; 3 cycles sync + TIMEOUT_CYC
        n_checks++;
        if (j < TIMEOUT_CYC - 7 || j > TIMEOUT_CYC - 3) begin
            n_fail++; $display("FAIL to_latency: got %0d, expected %0d..%0d", j, TIMEOUT_CYC - 7, TIMEOUT_CYC - 3);
        end
        n_checks++;
        if (legal !== 1'b0 || cnt_dd !== 0) begin
            n_fail++; $display("FAIL to_abort: got legal %b dd %0d, expected 0 0", legal, cnt_dd);
        end
        idle_gap();
        clear_mon();
        send_pre(32);
        send_bits(f, 0, 31, -1);
        idle_gap();
        n_checks++;
        if (cnt_dd !== 1 || cap_dd_rx !== f || cnt_to !== 0) begin
            n_fail++; $display("FAIL to_recover: got dd %0d rx %h to %0d, expected 1 %h 0", cnt_dd, cap_dd_rx, cnt_to, f);
        end
    endtask

    task automatic test_short_preamble();
        logic [31:0] f;
        f = {2'b01, 2'b01, 5'd5, 5'd4, 2'b10, 16'h0F0F};
        clear_mon();
        send_pre(31);
        send_bits(f, 0, 31, -1);
        idle_gap();
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        n_checks++;
        if (cnt_dd !== 1 || cap_dd_rx !== f) begin
            n_fail++; $display("FAIL pre31_accept: got dd %0d rx %h, expected 1 %h", cnt_dd, cap_dd_rx, f);
        end
`else
        n_checks++;
        if (cnt_pa !== 0 || cnt_info !== 0 || cnt_dd !== 0) begin
            n_fail++; $display("FAIL pre31_ignore: got %0d/%0d/%0d, expected 0/0/0", cnt_pa, cnt_info, cnt_dd);
        end
`endif
    endtask

    task automatic test_midframe_reset();
        logic [31:0] f;
        f = {2'b01, 2'b10, 5'd5, 5'd9, 2'b11, 16'h0000};
        clear_mon();
        send_pre(32);
        send_bits(f, 0, 19, 14);
        n_checks++;
        if (mdio_oe !== 1'b1) begin n_fail++; $display("FAIL mr_driving: got %b, expected 1", mdio_oe); end
        @(negedge clk_25m);
        rst_n = 1'b0;
        @(negedge clk_25m);
        n_checks++;
        if (mdio_oe !== 1'b0 || mdio_out !== 1'b1 || legal !== 1'b0 || rx_data !== 32'h0) begin
            n_fail++; $display("FAIL mr_state: got oe %b out %b legal %b rx %h, expected 0 1 0 0",
                               mdio_oe, mdio_out, legal, rx_data);
        end
        rst_n = 1'b1;
        idle_gap();
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_cl22_write();
        test_cl22_read();
        test_cl45_read_default();
        test_phy_mismatch();
        test_timeout();
        test_short_preamble();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
